// File: rtl/imm_pkg.sv
// Immediate-extension shared types: format codes, buffer states,
// and the DATA_WIDTH legality check used by imm_ext_pipe.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_B   = 3'b001,
    IMM_S   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

  localparam int IMM_DW_NARROW = 32;
  localparam int IMM_DW_WIDE   = 64;

  function automatic bit imm_dw_legal(input int w);
    return (w == IMM_DW_NARROW) || (w == IMM_DW_WIDE);
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready buffer (output reg + skid reg), payload W bits.
// Ports: clk_i, rst_i, flush_i, valid_i/ready_o/data_i in, valid_o/ready_i/data_o out.
module imm_skid_buf
  import imm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  sb_state_e    st_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         vld_q;
  logic         rdy_q;
  logic         acc;
  logic         pop;

  assign acc = valid_i & rdy_q;
  assign pop = vld_q & ready_i;

  // ready/valid are kept as their own flops so ready_o never
  // depends combinationally on ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= SB_EMPTY;
      vld_q  <= 1'b0;
      rdy_q  <= 1'b1;
      out_q  <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      st_q  <= SB_EMPTY;
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      unique case (st_q)
        SB_EMPTY: begin
          if (acc) begin
            out_q <= data_i;
            st_q  <= SB_ONE;
            vld_q <= 1'b1;
          end
        end
        SB_ONE: begin
          if (acc && pop) begin
            out_q <= data_i;
          end else if (acc) begin
            skid_q <= data_i;
            st_q   <= SB_FULL;
            rdy_q  <= 1'b0;
          end else if (pop) begin
            st_q  <= SB_EMPTY;
            vld_q <= 1'b0;
          end
        end
        SB_FULL: begin
          if (pop) begin
            out_q <= skid_q;
            st_q  <= SB_ONE;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          st_q  <= SB_EMPTY;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = rdy_q;
  assign valid_o = vld_q;
  assign data_o  = out_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// RISC-V immediate decode/extend with a 2-entry handshake buffer.
// Ports: clk_i, rst_i, flush_i, valid_i/ready_o, imm_src_i, instr_i, tag_i,
// valid_o/ready_i, imm_ext_o, tag_o (+ err_o with IMM_EXT_ILLEGAL_EN).
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            imm_src_i,
  input  logic [31:0]           instr_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] imm_ext_o,
`ifdef IMM_EXT_ILLEGAL_EN
  output logic                  err_o,
`endif
  output logic [TAG_WIDTH-1:0]  tag_o
);

  localparam bit DW_OK = imm_dw_legal(DATA_WIDTH);

  if (!DW_OK) begin : g_dw_bad
    $error("imm_ext_pipe: DATA_WIDTH must be 32 or 64");
  end

`ifdef IMM_EXT_ILLEGAL_EN
  localparam int EW = 1;
`else
  localparam int EW = 0;
`endif
  localparam int PW = DATA_WIDTH + TAG_WIDTH + EW;

  imm_src_e              src;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm;
  logic [PW-1:0]         pay_in;
  logic [PW-1:0]         pay_out;

  assign src = imm_src_e'(imm_src_i);

  // Every format fits in 32 bits with bit 31 as its sign (zero for
  // Z/SH/illegal), so one final sign-extension serves both widths.
  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      (src == IMM_I):
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      (src == IMM_B):
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                 instr_i[30:25], instr_i[11:8], 1'b0};
      (src == IMM_S):
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      (src == IMM_U):
        imm32 = {instr_i[31:12], 12'b0};
      (src == IMM_J):
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                 instr_i[20], instr_i[30:21], 1'b0};
      (src == IMM_Z):
        imm32 = {27'b0, instr_i[19:15]};
      (src == IMM_SH):
        imm32 = (DATA_WIDTH == IMM_DW_WIDE)
              ? {26'b0, instr_i[25:20]}
              : {27'b0, instr_i[24:20]};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = DATA_WIDTH'($signed(imm32));

`ifdef IMM_EXT_ILLEGAL_EN
  assign pay_in = {(src == IMM_BAD), tag_i, imm};
`else
  assign pay_in = {tag_i, imm};
`endif

  imm_skid_buf #(
    .W(PW)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (pay_in),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (pay_out)
  );

  assign imm_ext_o = pay_out[DATA_WIDTH-1:0];
  assign tag_o     = pay_out[DATA_WIDTH +: TAG_WIDTH];
`ifdef IMM_EXT_ILLEGAL_EN
  assign err_o     = pay_out[PW-1];
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: 32-bit and 64-bit instances,
// decode formats, back-pressure, flush and reset (err_o with IMM_EXT_ILLEGAL_EN).
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  logic        a_valid = 1'b0;
  logic        a_ready_o;
  logic [2:0]  a_src = 3'd0;
  logic [31:0] a_instr = 32'd0;
  logic [4:0]  a_tag = 5'd0;
  logic        a_valid_o;
  logic        a_ready_i = 1'b1;
  logic [31:0] a_imm;
  logic [4:0]  a_tag_o;

  logic        b_valid = 1'b0;
  logic        b_ready_o;
  logic [2:0]  b_src = 3'd0;
  logic [31:0] b_instr = 32'd0;
  logic [4:0]  b_tag = 5'd0;
  logic        b_valid_o;
  logic [63:0] b_imm;
  logic [4:0]  b_tag_o;

`ifdef IMM_EXT_ILLEGAL_EN
  logic a_err;
  logic b_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .valid_i   (a_valid),
    .ready_o   (a_ready_o),
    .imm_src_i (a_src),
    .instr_i   (a_instr),
    .tag_i     (a_tag),
    .valid_o   (a_valid_o),
    .ready_i   (a_ready_i),
    .imm_ext_o (a_imm),
`ifdef IMM_EXT_ILLEGAL_EN
    .err_o     (a_err),
`endif
    .tag_o     (a_tag_o)
  );

  imm_ext_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(5)) dut_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (1'b0),
    .valid_i   (b_valid),
    .ready_o   (b_ready_o),
    .imm_src_i (b_src),
    .instr_i   (b_instr),
    .tag_i     (b_tag),
    .valid_o   (b_valid_o),
    .ready_i   (1'b1),
    .imm_ext_o (b_imm),
`ifdef IMM_EXT_ILLEGAL_EN
    .err_o     (b_err),
`endif
    .tag_o     (b_tag_o)
  );

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic [2:0] s, input logic [31:0] i,
                       input logic [4:0] t);
    a_valid = 1'b1;
    a_src   = s;
    a_instr = i;
    a_tag   = t;
  endtask

  task automatic xfer_a(input string name, input logic [2:0] s,
                        input logic [31:0] i, input logic [4:0] t,
                        input logic [31:0] exp);
    drv_a(s, i, t);
    step();
    chk({name, "_vld"}, 64'(a_valid_o), 64'd1);
    chk({name, "_imm"}, 64'(a_imm), 64'(exp));
    chk({name, "_tag"}, 64'(a_tag_o), 64'(t));
    chk({name, "_rdy"}, 64'(a_ready_o), 64'd1);
  endtask

  task automatic xfer_b(input string name, input logic [2:0] s,
                        input logic [31:0] i, input logic [63:0] exp);
    b_valid = 1'b1;
    b_src   = s;
    b_instr = i;
    step();
    chk({name, "_vld"}, 64'(b_valid_o), 64'd1);
    chk({name, "_imm"}, b_imm, exp);
  endtask

  initial begin
    step();
    step();
    chk("rst_a_vld", 64'(a_valid_o), 64'd0);
    chk("rst_a_rdy", 64'(a_ready_o), 64'd1);
    chk("rst_a_imm", 64'(a_imm), 64'd0);
    chk("rst_a_tag", 64'(a_tag_o), 64'd0);
    chk("rst_b_imm", b_imm, 64'd0);
`ifdef IMM_EXT_ILLEGAL_EN
    chk("rst_a_err", 64'(a_err), 64'd0);
`endif
    rst = 1'b0;

    // Back-to-back stream with ready_i high: one result per cycle.
    drv_a(3'b000, 32'hFFF0_0093, 5'd1);
    #1;
    chk("lat_pre_vld", 64'(a_valid_o), 64'd0);
    xfer_a("i_neg1", 3'b000, 32'hFFF0_0093, 5'd1, 32'hFFFF_FFFF);
    xfer_a("b_neg4", 3'b001, 32'hFE00_0EE3, 5'd2, 32'hFFFF_FFFC);
    xfer_a("s_12",   3'b010, 32'h0011_2623, 5'd3, 32'h0000_000C);
    xfer_a("j_neg4", 3'b100, 32'hFFDF_F06F, 5'd4, 32'hFFFF_FFFC);
    xfer_a("u_pos",  3'b011, 32'h1234_5037, 5'd5, 32'h1234_5000);
    xfer_a("z_15",   3'b101, 32'h000A_8073, 5'd6, 32'h0000_0015);
    xfer_a("sh32",   3'b110, 32'h03F0_0013, 5'd7, 32'h0000_001F);
    xfer_a("bad",    3'b111, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000);
`ifdef IMM_EXT_ILLEGAL_EN
    chk("bad_err", 64'(a_err), 64'd1);
`endif
    xfer_a("i_5",    3'b000, 32'h0050_0093, 5'd9, 32'h0000_0005);
`ifdef IMM_EXT_ILLEGAL_EN
    chk("i_5_err", 64'(a_err), 64'd0);
`endif
    a_valid = 1'b0;
    step();
    chk("drain_vld", 64'(a_valid_o), 64'd0);

    // Back-pressure: ready_i low for three edges, tags 1,2,3 offered.
    a_ready_i = 1'b0;
    drv_a(3'b000, 32'h0050_0093, 5'd1);
    step();
    chk("bp1_tag", 64'(a_tag_o), 64'd1);
    chk("bp1_rdy", 64'(a_ready_o), 64'd1);
    drv_a(3'b000, 32'h0050_0093, 5'd2);
    step();
    chk("bp2_rdy", 64'(a_ready_o), 64'd0);
    chk("bp2_tag", 64'(a_tag_o), 64'd1);
    drv_a(3'b000, 32'h0050_0093, 5'd3);
    step();
    chk("bp3_rdy", 64'(a_ready_o), 64'd0);
    chk("bp3_tag", 64'(a_tag_o), 64'd1);
    chk("bp3_imm", 64'(a_imm), 64'd5);
    a_ready_i = 1'b1;
    step();
    chk("bp4_tag", 64'(a_tag_o), 64'd2);
    chk("bp4_rdy", 64'(a_ready_o), 64'd1);
    step();
    chk("bp5_tag", 64'(a_tag_o), 64'd3);
    chk("bp5_vld", 64'(a_valid_o), 64'd1);
    a_valid = 1'b0;
    step();
    chk("bp6_vld", 64'(a_valid_o), 64'd0);

    // Flush while FULL with a new input offered.
    a_ready_i = 1'b0;
    drv_a(3'b000, 32'h0050_0093, 5'd10);
    step();
    drv_a(3'b000, 32'h0050_0093, 5'd11);
    step();
    chk("fl_full_rdy", 64'(a_ready_o), 64'd0);
    drv_a(3'b000, 32'h0050_0093, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    a_valid = 1'b0;
    chk("fl_vld", 64'(a_valid_o), 64'd0);
    chk("fl_rdy", 64'(a_ready_o), 64'd1);
    a_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_after_vld", 64'(a_valid_o), 64'd0);
    end

    // Reset mid-transfer discards buffered data.
    a_ready_i = 1'b0;
    drv_a(3'b000, 32'h0050_0093, 5'd20);
    step();
    drv_a(3'b000, 32'h0050_0093, 5'd21);
    rst = 1'b1;
    step();
    chk("mr_vld", 64'(a_valid_o), 64'd0);
    chk("mr_rdy", 64'(a_ready_o), 64'd1);
    chk("mr_imm", 64'(a_imm), 64'd0);
    chk("mr_tag", 64'(a_tag_o), 64'd0);
    rst = 1'b0;
    a_valid = 1'b0;
    a_ready_i = 1'b1;
    step();
    chk("mr_idle_vld", 64'(a_valid_o), 64'd0);
    drv_a(3'b000, 32'hFFF0_0093, 5'd22);
    #1;
    chk("mr_pre_vld", 64'(a_valid_o), 64'd0);
    step();
    a_valid = 1'b0;
    chk("mr_post_vld", 64'(a_valid_o), 64'd1);
    chk("mr_post_tag", 64'(a_tag_o), 64'd22);

    // 64-bit instance.
    xfer_b("w_u", 3'b011, 32'h8000_0037, 64'hFFFF_FFFF_8000_0000);
    xfer_b("w_z", 3'b101, 32'h000F_8073, 64'h0000_0000_0000_001F);
    xfer_b("w_sh", 3'b110, 32'h03F0_0013, 64'h0000_0000_0000_003F);
    xfer_b("w_i", 3'b000, 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF);
    xfer_b("w_s", 3'b010, 32'h0011_2623, 64'h0000_0000_0000_000C);
    b_valid = 1'b0;
    step();
    chk("w_drain_vld", 64'(b_valid_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output immediate width; legal values 32, 64 only.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, width of the sideband tag carried alongside each immediate.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, which discards all buffered entries.
REQ-006 SHALL have ports valid_i (input, 1) and ready_o (output, 1), the upstream handshake.
REQ-007 SHALL have port imm_src_i, input, 3, the immediate format select.
REQ-008 SHALL have port instr_i, input, 32, the raw instruction word.
REQ-009 SHALL have port tag_i, input, TAG_WIDTH, the sideband tag.
REQ-010 SHALL have ports valid_o (output, 1) and ready_i (input, 1), the downstream handshake.
REQ-011 SHALL have ports imm_ext_o (output, DATA_WIDTH) and tag_o (output, TAG_WIDTH), the result.

Function
REQ-012 SHALL decode imm_src_i as follows:
- 000 I
- 001 B
- 010 S
- 011 U
- 100 J
- 101 Z: instr[19:15] zero-extended (CSR zimm)
- 110 SH: shift amount zero-extended, instr[24:20] when DATA_WIDTH=32, instr[25:20] when 64
- 111 illegal: result zero
REQ-013 SHALL sign-extend I/B/S/J from instr[31] to DATA_WIDTH; SHALL build U as instr[31:12]<<12 sign-extended from bit 31 to DATA_WIDTH.
REQ-014 SHALL compute the immediate combinationally from the inputs and register it on acceptance; latency valid_i&ready_o to valid_o is exactly 1 cycle.
REQ-015 SHALL use a 2-entry storage: one output register and one skid register; throughput 1/cycle when ready_i stays high.
REQ-016 SHALL treat a transfer as occurring only in a cycle with valid&ready high; output data SHALL hold stable while valid_o=1 and ready_i=0.
REQ-017 SHALL drive ready_o as a registered "skid register empty" flag, with no combinational path from ready_i.
REQ-018 SHALL use state EMPTY/ONE/FULL:
- EMPTY: on accept, go to ONE.
- ONE: on accept without pop, go to FULL; on pop without accept, go to EMPTY; accept with pop stays ONE.
- FULL: on pop, the skid entry moves to the output register and the state goes to ONE.
REQ-019 SHALL deliver entries strictly in acceptance order.
REQ-020 SHALL give flush_i priority over a simultaneous accept and pop: next state EMPTY, valid_o=0, ready_o=1; an input offered in the flush cycle is dropped.

Reset
REQ-021 SHALL, while rst_i=1 at a clock edge, enter EMPTY with valid_o=0, ready_o=1, imm_ext_o=0, tag_o=0 (err_o=0 when present).
REQ-022 SHALL, when reset is asserted mid-transfer, discard all entries; the first valid_o SHALL come no earlier than 1 cycle after the first accept following reset release.

Configuration
REQ-023 SHALL, when macro IMM_EXT_ILLEGAL_EN is defined, add output err_o (1 bit), registered alongside each entry, equal to 1 exactly when imm_src_i=111 at acceptance.
REQ-024 SHALL, when IMM_EXT_ILLEGAL_EN is undefined, omit err_o; code 111 still yields zero with no other indication.

Structure
REQ-025 SHALL place the imm_src_e enum (the 8 codes) and the DATA_WIDTH legality check constant in package imm_pkg.
REQ-026 SHALL implement the 2-entry buffer as sub-module imm_skid_buf, parametrised on payload width; the decode stays in imm_ext_pipe.

Verification
REQ-027 SHALL cover: DATA_WIDTH=32, I, instr 0xFFF00093 -> imm_ext_o 0xFFFFFFFF one cycle after accept.
REQ-028 SHALL cover: B, instr 0xFE000EE3 -> 0xFFFFFFFC.
REQ-029 SHALL cover: DATA_WIDTH=64, U, instr 0x80000037 -> 0xFFFFFFFF80000000; Z, instr[19:15]=11111 -> 0x1F.
REQ-030 SHALL cover back-pressure: ready_i=0 for 3 cycles while tags 1,2,3 are offered back-to-back:
- tags 1 and 2 accepted; ready_o falls the cycle after tag 2.
- tag 3 stalls.
- after ready_i=1, tags emerge in order 1,2,3 with no loss or duplication.
REQ-031 SHALL cover: flush_i in the same cycle as valid_i in state FULL -> next cycle valid_o=0, ready_o=1, and no entry is later emitted.
REQ-032 SHALL cover, with IMM_EXT_ILLEGAL_EN defined: imm_src_i=111 -> imm_ext_o 0, err_o 1; the following I-type entry -> err_o 0.
